// File: rtl/vga_timing_rx.sv
// vga_timing_rx: receive-side VGA timing recovery and pixel capture.
// Registers the pin-level RGB444 and active-low syncs, measures line and
// frame length, locks onto a stable raster and emits pixel-qualified RGB
// with recovered x/y coordinates.
// Optional feature macro: VGA_RX_CRC_EN adds a per-frame CRC-16-CCITT over
// the valid pixels; without it frame_crc and crc_valid are tied to 0.
module vga_timing_rx #(
  parameter int unsigned H_SYNC_TO_ACTIVE = 144,
  parameter int unsigned H_ACTIVE         = 640,
  parameter int unsigned V_SYNC_TO_ACTIVE = 34,
  parameter int unsigned V_ACTIVE         = 480
) (
  input  logic        rst,
  input  logic        clk,
  input  logic [3:0]  i_vga_r,
  input  logic [3:0]  i_vga_g,
  input  logic [3:0]  i_vga_b,
  input  logic        i_vga_hsync,
  input  logic        i_vga_vsync,
  output logic        o_pix_valid,
  output logic [9:0]  o_pix_x,
  output logic [9:0]  o_pix_y,
  output logic [11:0] o_pix_rgb,
  output logic        o_frame_start,
  output logic        o_line_start,
  output logic        o_locked,
  output logic [10:0] o_h_total_meas,
  output logic [9:0]  o_v_total_meas,
  output logic        o_sync_error,
  output logic [15:0] o_frame_crc,
  output logic        o_crc_valid
);

  localparam logic [10:0] HStart = 11'(H_SYNC_TO_ACTIVE);
  localparam logic [10:0] HEnd   = 11'(H_SYNC_TO_ACTIVE + H_ACTIVE);
  localparam logic [9:0]  VStart = 10'(V_SYNC_TO_ACTIVE);
  localparam logic [9:0]  VEnd   = 10'(V_SYNC_TO_ACTIVE + V_ACTIVE);
  localparam logic [10:0] HSat   = 11'h7ff;
  localparam logic [9:0]  VSat   = 10'h3ff;

  typedef enum logic [1:0] {StUnlocked, StCheck1, StLocked} lock_state_e;

  // Input stage
  logic [11:0] r_rgb;
  logic        r_hs, r_vs, r_hs_d, r_vs_d;

  // Timing recovery state
  logic [10:0] r_hcnt;
  logic [9:0]  r_vline;
  logic        r_vs_pending;
  logic        r_seen_vs;
  logic        r_frame_bad;
  logic [10:0] r_h_total;
  logic [9:0]  r_v_total;
  lock_state_e r_state, w_state_d;
  logic        w_sync_err_d;

  // Output stage
  logic        r_pix_valid;
  logic [9:0]  r_pix_x, r_pix_y;
  logic [11:0] r_pix_rgb;
  logic        r_frame_start, r_line_start, r_sync_error;

  // Combinational datapath
  logic        w_hs_edge, w_vs_edge;
  logic [10:0] w_k, w_line_len, w_px_full;
  logic [9:0]  w_vline, w_v_len, w_py;
  logic        w_mismatch, w_sat, w_frame_end, w_frame_clean, w_v_same, w_active;

  // Register every pin once; syncs idle high, colour idles at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb  <= '0;
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
      r_hs_d <= 1'b1;
      r_vs_d <= 1'b1;
    end else begin
      r_rgb  <= {i_vga_r, i_vga_g, i_vga_b};
      r_hs   <= i_vga_hsync;
      r_vs   <= i_vga_vsync;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
    end
  end

  // Sample index, line index, edge decode and active-window qualification
  always_comb begin
    w_hs_edge   = r_hs_d & ~r_hs;
    w_vs_edge   = r_vs_d & ~r_vs;
    w_line_len  = (r_hcnt == HSat) ? HSat : r_hcnt + 11'd1;
    w_k         = w_hs_edge ? 11'd0 : w_line_len;
    w_sat       = (w_k == HSat);
    w_mismatch  = w_hs_edge && (w_line_len != r_h_total);
    w_frame_end = w_hs_edge && r_vs_pending;
    w_v_len     = (r_vline == VSat) ? VSat : r_vline + 10'd1;
    w_vline     = r_vline;
    if (w_hs_edge) begin
      w_vline = r_vs_pending ? 10'd0 : w_v_len;
    end
    // A frame only counts once its start was anchored by a vsync edge
    w_frame_clean = r_seen_vs && !r_frame_bad && !w_mismatch;
    w_v_same      = (w_v_len == r_v_total);
    w_active      = (r_state == StLocked) &&
                    (w_k >= HStart) && (w_k < HEnd) &&
                    (w_vline >= VStart) && (w_vline < VEnd);
    w_px_full     = w_k - HStart;
    w_py          = w_vline - VStart;
  end

  // Line/frame counters and measurements
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt       <= '0;
      r_vline      <= '0;
      r_vs_pending <= 1'b0;
      r_seen_vs    <= 1'b0;
      r_frame_bad  <= 1'b0;
      r_h_total    <= '0;
      r_v_total    <= '0;
    end else begin
      r_hcnt  <= w_k;
      r_vline <= w_vline;
      // hsync edge consumes the old pending flag before a coincident vsync edge re-arms it
      if (w_vs_edge) begin
        r_vs_pending <= 1'b1;
      end else if (w_hs_edge) begin
        r_vs_pending <= 1'b0;
      end
      if (w_hs_edge) begin
        r_h_total <= w_line_len;
      end
      if (w_frame_end) begin
        r_v_total   <= w_v_len;
        r_seen_vs   <= 1'b1;
        r_frame_bad <= 1'b0;
      end else if (w_mismatch || w_sat) begin
        r_frame_bad <= 1'b1;
      end
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StUnlocked;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Lock FSM next state; sync_error only when dropping out of LOCKED
  always_comb begin
    w_state_d    = r_state;
    w_sync_err_d = 1'b0;
    unique case (r_state)
      StUnlocked: begin
        if (w_frame_end && w_frame_clean) begin
          w_state_d = StCheck1;
        end
      end
      StCheck1: begin
        if (w_mismatch || w_sat) begin
          w_state_d = StUnlocked;
        end else if (w_frame_end) begin
          w_state_d = (w_frame_clean && w_v_same) ? StLocked : StUnlocked;
        end
      end
      StLocked: begin
        if (w_mismatch || w_sat || (w_frame_end && !w_v_same)) begin
          w_state_d    = StUnlocked;
          w_sync_err_d = 1'b1;
        end
      end
      default: w_state_d = StUnlocked;
    endcase
  end

  // Output register: pixel fields forced to zero outside the active window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_valid   <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_rgb     <= '0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
      r_sync_error  <= 1'b0;
    end else begin
      r_pix_valid   <= w_active;
      r_pix_x       <= w_active ? w_px_full[9:0] : 10'd0;
      r_pix_y       <= w_active ? w_py : 10'd0;
      r_pix_rgb     <= w_active ? r_rgb : 12'd0;
      r_line_start  <= w_active && (w_px_full == 11'd0);
      r_frame_start <= w_active && (w_px_full == 11'd0) && (w_py == 10'd0);
      r_sync_error  <= w_sync_err_d;
    end
  end

  assign o_pix_valid    = r_pix_valid;
  assign o_pix_x        = r_pix_x;
  assign o_pix_y        = r_pix_y;
  assign o_pix_rgb      = r_pix_rgb;
  assign o_frame_start  = r_frame_start;
  assign o_line_start   = r_line_start;
  assign o_locked       = (r_state == StLocked);
  assign o_h_total_meas = r_h_total;
  assign o_v_total_meas = r_v_total;
  assign o_sync_error   = r_sync_error;

`ifdef VGA_RX_CRC_EN
  logic [15:0] r_crc, r_frame_crc, w_crc_next;
  logic        r_crc_valid;

  // CRC-16-CCITT, 12 data bits per call, MSB first
  function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] n;
    n = c;
    for (int i = 11; i >= 0; i--) begin
      if (n[15] ^ d[i]) begin
        n = {n[14:0], 1'b0} ^ 16'h1021;
      end else begin
        n = {n[14:0], 1'b0};
      end
    end
    return n;
  endfunction

  // Fold in the pixel currently on the outputs
  always_comb begin
    w_crc_next = r_crc;
    if (r_pix_valid) begin
      w_crc_next = crc12(r_crc, r_pix_rgb);
    end
  end

  // Publish at each vsync edge while locked; restart the running CRC at every vsync edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc       <= 16'hffff;
      r_frame_crc <= '0;
      r_crc_valid <= 1'b0;
    end else begin
      r_crc_valid <= 1'b0;
      if (w_vs_edge) begin
        r_crc <= 16'hffff;
        if (r_state == StLocked) begin
          r_frame_crc <= w_crc_next;
          r_crc_valid <= 1'b1;
        end
      end else begin
        r_crc <= w_crc_next;
      end
    end
  end

  assign o_frame_crc = r_frame_crc;
  assign o_crc_valid = r_crc_valid;
`else
  assign o_frame_crc = 16'd0;
  assign o_crc_valid = 1'b0;
`endif

endmodule
